// File: rtl/mem_request_sequencer_pkg.sv
// Shared types and address-map constants for the memory request sequencer.
// Imported by the sequencer and its region decoder.
package mem_request_sequencer_pkg;

  localparam logic [15:0] ROM_BASE  = 16'h0000;
  localparam logic [15:0] ROM_LIMIT = 16'h001F;
  localparam logic [15:0] IO_BASE   = 16'h0020;
  localparam logic [15:0] IO_LIMIT  = 16'h003F;
  localparam logic [15:0] RAM_BASE  = 16'h0800;
  localparam logic [15:0] RAM_LIMIT = 16'h0FFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_t;

  typedef enum logic {
    PORT_FETCH,
    PORT_DATA
  } port_t;

  function automatic logic in_range(
    input logic [15:0] addr,
    input logic [15:0] base,
    input logic [15:0] limit
  );
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address-map decoder: word address -> region flags.
// Shared with memory_controller so both agree on the map.
module mem_region_decode
  import mem_request_sequencer_pkg::*;
(
  input  logic [15:0] addr,
  output logic        is_rom,
  output logic        is_io,
  output logic        is_ram,
  output logic        unmapped
);

  assign is_rom   = in_range(addr, ROM_BASE, ROM_LIMIT);
  assign is_io    = in_range(addr, IO_BASE, IO_LIMIT);
  assign is_ram   = in_range(addr, RAM_BASE, RAM_LIMIT);
  assign unmapped = ~(is_rom | is_io | is_ram);

endmodule

// File: rtl/mem_request_sequencer.sv
// Arbitrates fetch and load/store ports onto one memory_controller,
// holds the access for ACCESS_CYCLES and returns data with a ready pulse.
module mem_request_sequencer
  import mem_request_sequencer_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ready,
  output logic [31:0] fetch_data,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [15:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic        bus_error,
  output logic [15:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cycles
    $error("ACCESS_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  port_t       port_r;
  port_t       last_grant;
  logic [3:0]  cnt;
  logic [15:0] addr_r;
  logic [31:0] wdata_r;
  logic        we_r;

  logic is_rom;
  logic is_io;
  logic is_ram;
  logic unmapped;

  mem_region_decode u_decode (
    .addr     (addr_r),
    .is_rom   (is_rom),
    .is_io    (is_io),
    .is_ram   (is_ram),
    .unmapped (unmapped)
  );

  logic        writable;
  logic        flagged;
  logic        grant_fetch;
  logic        any_req;
  logic [31:0] rd_value;

  // Region qualification and arbitration (alternate on ties)
  always_comb begin
    writable    = is_ram | is_io;
    flagged     = unmapped | (we_r & is_rom);
    any_req     = fetch_req | data_req;
    grant_fetch = fetch_req &
                  (~data_req | (last_grant == PORT_DATA));
    rd_value    = unmapped ? 32'h0 : mem_rdata;
  end

  // Memory-side drive: address held through ACCESS and RESPOND
  always_comb begin
    mem_address = (state == IDLE) ? 16'h0 : addr_r;
    mem_wdata   = (state == ACCESS) ? wdata_r : 32'h0;
    mem_we      = (state == ACCESS) & we_r & writable;
  end

  // Sequencer FSM with registered ready/error/data outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      port_r      <= PORT_FETCH;
      last_grant  <= PORT_FETCH;
      cnt         <= 4'h0;
      addr_r      <= 16'h0;
      wdata_r     <= 32'h0;
      we_r        <= 1'b0;
      fetch_ready <= 1'b0;
      data_ready  <= 1'b0;
      bus_error   <= 1'b0;
      fetch_data  <= 32'h0;
      data_rdata  <= 32'h0;
    end else begin
      fetch_ready <= 1'b0;
      data_ready  <= 1'b0;
      bus_error   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            if (grant_fetch) begin
              port_r     <= PORT_FETCH;
              last_grant <= PORT_FETCH;
              addr_r     <= fetch_addr;
              wdata_r    <= 32'h0;
              we_r       <= 1'b0;
            end else begin
              port_r     <= PORT_DATA;
              last_grant <= PORT_DATA;
              addr_r     <= data_addr;
              wdata_r    <= data_wdata;
              we_r       <= data_we;
            end
            cnt   <= CNT_INIT;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'h0) begin
            if (port_r == PORT_FETCH) begin
              fetch_ready <= 1'b1;
              if (!we_r) fetch_data <= rd_value;
            end else begin
              data_ready <= 1'b1;
              if (!we_r) data_rdata <= rd_value;
            end
            bus_error <= flagged;
            state     <= RESPOND;
          end else begin
            cnt <= cnt - 4'h1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Scoreboard bench for mem_request_sequencer (ACCESS_CYCLES=1 and 3).
// Expected responses are queued at issue and popped on each ready pulse.
module tb_mem_request_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = 16'h0;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [15:0] data_addr = 16'h0;
  logic [31:0] data_wdata = 32'h0;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic        bus_error;
  logic [15:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic        f3_req = 1'b0;
  logic [15:0] f3_addr = 16'h0;
  logic        f3_ready;
  logic [31:0] f3_data;
  logic        d3_req = 1'b0;
  logic        d3_we = 1'b0;
  logic [15:0] d3_addr = 16'h0;
  logic [31:0] d3_wdata = 32'h0;
  logic        d3_ready;
  logic [31:0] d3_rdata;
  logic        e3_error;
  logic [15:0] m3_address;
  logic [31:0] m3_wdata;
  logic        m3_we;
  logic [31:0] m3_rdata;

  mem_request_sequencer #(.ACCESS_CYCLES(1)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_rdata(data_rdata),
    .bus_error(bus_error),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_request_sequencer #(.ACCESS_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset),
    .fetch_req(f3_req), .fetch_addr(f3_addr),
    .fetch_ready(f3_ready), .fetch_data(f3_data),
    .data_req(d3_req), .data_we(d3_we),
    .data_addr(d3_addr), .data_wdata(d3_wdata),
    .data_ready(d3_ready), .data_rdata(d3_rdata),
    .bus_error(e3_error),
    .mem_address(m3_address), .mem_wdata(m3_wdata),
    .mem_we(m3_we), .mem_rdata(m3_rdata)
  );

  typedef struct {
    bit          port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          we_count = 0;
  logic [31:0] last_fetch = 32'h0;
  logic [31:0] last_data = 32'h0;
  logic [31:0] mem  [0:65535];
  logic [31:0] refm [0:65535];

  function automatic logic [31:0] default_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  function automatic bit tb_rom(input logic [15:0] a);
    return a <= 16'h001F;
  endfunction
  function automatic bit tb_io(input logic [15:0] a);
    return a >= 16'h0020 && a <= 16'h003F;
  endfunction
  function automatic bit tb_ram(input logic [15:0] a);
    return a >= 16'h0800 && a <= 16'h0FFF;
  endfunction

  assign mem_rdata = mem[mem_address];
  assign m3_rdata  = default_word(m3_address);

  always @(posedge clock) begin
    if (mem_we) mem[mem_address] <= mem_wdata;
  end

  // Response monitor: pop and compare on each ready pulse
  always @(negedge clock) begin
    if (mem_we) we_count++;
    if (!reset) begin
      if (fetch_ready || data_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready fetch=%0b data=%0b", fetch_ready, data_ready);
        end else begin
          mon_e = sb.pop_front();
          if ({fetch_ready, data_ready} !== (mon_e.port ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL grant_port got f=%0b d=%0b want port=%0d",
                     fetch_ready, data_ready, mon_e.port);
          end
          checks++;
          if ((mon_e.port ? data_rdata : fetch_data) !== mon_e.data) begin
            errors++;
            $display("FAIL rdata got %h want %h",
                     mon_e.port ? data_rdata : fetch_data, mon_e.data);
          end
          checks++;
          if (bus_error !== mon_e.err) begin
            errors++;
            $display("FAIL bus_error got %0b want %0b", bus_error, mon_e.err);
          end
        end
      end else if (bus_error) begin
        checks++;
        errors++;
        $display("FAIL stray_bus_error got 1 want 0");
      end
    end
  end

  task automatic expect_access(input bit port, input bit we,
                               input logic [15:0] a, input logic [31:0] wd);
    exp_t e;
    bit mapped;
    mapped = tb_rom(a) || tb_io(a) || tb_ram(a);
    e.port = port;
    e.err  = !mapped || (we && tb_rom(a));
    if (we) begin
      if (tb_io(a) || tb_ram(a)) refm[a] = wd;
      e.data = port ? last_data : last_fetch;
    end else begin
      e.data = mapped ? refm[a] : 32'h0;
      if (port) last_data = e.data;
      else last_fetch = e.data;
    end
    sb.push_back(e);
  endtask

  task automatic run_single(input bit port, input bit we,
                            input logic [15:0] a, input logic [31:0] wd,
                            input int we_exp, input string name);
    int k;
    int we_k;
    bit got;
    expect_access(port, we, a, wd);
    we_count = 0;
    k = 0;
    we_k = -1;
    got = 0;
    if (port) begin
      data_req = 1'b1; data_we = we; data_addr = a; data_wdata = wd;
    end else begin
      fetch_req = 1'b1; fetch_addr = a;
    end
    while (!got && k < 20) begin
      @(posedge clock); #1;
      k++;
      if (mem_we && we_k < 0) we_k = k;
      if (port ? data_ready : fetch_ready) got = 1;
      if (k == 1) begin
        data_addr = a ^ 16'h0800;
        data_wdata = ~wd;
        data_we = ~we;
        fetch_addr = a ^ 16'h0800;
      end
    end
    fetch_req = 1'b0;
    data_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout waited %0d cycles want ready at 2", name, k);
      void'(sb.pop_back());
    end else if (k != 2) begin
      errors++;
      $display("FAIL %s_latency got %0d want 2", name, k);
    end
    @(posedge clock); #1;
    checks++;
    if (we_count != we_exp) begin
      errors++;
      $display("FAIL %s_we_cycles got %0d want %0d", name, we_count, we_exp);
    end
    if (we_exp > 0) begin
      checks++;
      if (we_k != 1) begin
        errors++;
        $display("FAIL %s_we_cycle got %0d want 1", name, we_k);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({fetch_ready, data_ready, bus_error, mem_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {fetch_ready, data_ready, bus_error, mem_we});
    end
    checks++;
    if (mem_address !== 16'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got %h/%h want 0", mem_address, mem_wdata);
    end
    checks++;
    if (fetch_data !== 32'h0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 0", fetch_data, data_rdata);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_fetch();
    run_single(1'b0, 1'b0, 16'h0004, 32'h0, 0, "fetch_rom");
    run_single(1'b0, 1'b0, 16'h0820, 32'h0, 0, "fetch_ram");
  endtask

  task automatic test_store_load();
    run_single(1'b1, 1'b1, 16'h0800, 32'h12345678, 1, "store_ram");
    run_single(1'b1, 1'b0, 16'h0800, 32'h0, 0, "load_ram");
    run_single(1'b1, 1'b1, 16'h0025, 32'hA5A50F0F, 1, "store_io");
    run_single(1'b1, 1'b0, 16'h0025, 32'h0, 0, "load_io");
    run_single(1'b1, 1'b0, 16'h0FFF, 32'h0, 0, "load_ram_top");
  endtask

  task automatic test_errors();
    run_single(1'b1, 1'b1, 16'h0010, 32'h55AA55AA, 0, "store_rom");
    run_single(1'b1, 1'b0, 16'h0010, 32'h0, 0, "load_rom");
    run_single(1'b1, 1'b0, 16'h2000, 32'h0, 0, "load_unmapped");
    run_single(1'b0, 1'b0, 16'h0040, 32'h0, 0, "fetch_past_io");
    run_single(1'b1, 1'b0, 16'h07FF, 32'h0, 0, "load_below_ram");
    run_single(1'b1, 1'b1, 16'h1000, 32'h11112222, 0, "store_past_ram");
  endtask

  task automatic test_back_to_back();
    int k;
    int n;
    int prev;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    last_fetch = 32'h0;
    last_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      expect_access(1'b1, 1'b0, 16'h0810, 32'h0);
      expect_access(1'b0, 1'b0, 16'h0020, 32'h0);
    end
    fetch_addr = 16'h0020;
    data_addr = 16'h0810;
    data_we = 1'b0;
    fetch_req = 1'b1;
    data_req = 1'b1;
    k = 0;
    n = 0;
    prev = -1;
    while (n < 6 && k < 60) begin
      @(posedge clock); #1;
      k++;
      if (fetch_ready || data_ready) begin
        n++;
        if (prev >= 0) begin
          checks++;
          if (k - prev != 3) begin
            errors++;
            $display("FAIL b2b_interval got %0d want 3", k - prev);
          end
        end
        prev = k;
      end
    end
    fetch_req = 1'b0;
    data_req = 1'b0;
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL b2b_count got %0d want 6", n);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    data_req = 1'b1;
    data_we = 1'b1;
    data_addr = 16'h0900;
    data_wdata = 32'hCAFEF00D;
    @(posedge clock); #1;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_we_before got %0b want 1", mem_we);
    end
    reset = 1'b1;
    data_req = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({mem_we, data_ready, fetch_ready, bus_error} !== 4'b0) begin
      errors++;
      $display("FAIL mid_flags got %b want 0000",
               {mem_we, data_ready, fetch_ready, bus_error});
    end
    checks++;
    if (mem_address !== 16'h0 || mem_wdata !== 32'h0 ||
        data_rdata !== 32'h0 || fetch_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_outputs got %h %h %h %h want 0",
               mem_address, mem_wdata, data_rdata, fetch_data);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    last_fetch = 32'h0;
    last_data = 32'h0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_access3();
    int k;
    bit got;
    d3_req = 1'b1;
    d3_we = 1'b0;
    d3_addr = 16'h0840;
    k = 0;
    got = 0;
    while (!got && k < 20) begin
      @(posedge clock); #1;
      k++;
      if (d3_ready) got = 1;
      else if (k <= 3) begin
        checks++;
        if (m3_address !== 16'h0840) begin
          errors++;
          $display("FAIL ac3_addr cycle %0d got %h want 0840", k, m3_address);
        end
      end
      if (k == 1) d3_addr = 16'h0000;
    end
    d3_req = 1'b0;
    checks++;
    if (k != 4 || !got) begin
      errors++;
      $display("FAIL ac3_latency got %0d want 4", k);
    end
    checks++;
    if (d3_rdata !== default_word(16'h0840) || e3_error !== 1'b0) begin
      errors++;
      $display("FAIL ac3_data got %h err %0b want %h err 0",
               d3_rdata, e3_error, default_word(16'h0840));
    end
    @(posedge clock); #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = default_word(16'(i));
      refm[i] = default_word(16'(i));
    end
    mem[16'h0004]  = 32'hDEADBEEF;
    refm[16'h0004] = 32'hDEADBEEF;
    test_reset();
    test_fetch();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_access3();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
